multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore/Mealy control FSM that sequences the shared MIPS datapath (PC, unified memory, register heap, ALU)
//  over multiple clocks per instruction instead of one. Decodes opcode from the instruction register and drives
//  every datapath mux/enable; waits on a memory ready handshake; traps illegal opcodes and memory timeouts.
//  Sits beside the datapath in place of the single-cycle controlUnit.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles a memory state waits for memReady before fault (1..255)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  synchronous reset, active-high
//  opcode       in   6  instruction[31:26] from instruction register
//  zero         in   1  ALU zero flag
//  memReady     in   1  memory has completed current read/write this cycle
//  pcWrite      out  1  load PC
//  pcSrc        out  2  00 ALU result(PC+4), 01 ALUOut(branch target), 10 jump target
//  irWrite      out  1  load instruction register
//  iord         out  1  memory address: 0 PC, 1 ALUOut
//  memRead      out  1  memory read request
//  memWrite     out  1  memory write request
//  regWrite     out  1  register heap write enable
//  regDst       out  1  write reg: 0 rt, 1 rd
//  memToReg     out  1  write data: 0 ALUOut, 1 memory data reg
//  aluSrcA      out  1  0 PC, 1 reg1Data
//  aluSrcB      out  2  00 reg2Data, 01 const 4, 10 signExt, 11 signExt<<2
//  aluOp        out  2  00 add, 01 sub, 10 funct-decoded
//  instrDone    out  1  one-cycle pulse in the final cycle of each instruction
//  fault        out  2  sticky: 00 none, 01 illegal opcode, 10 memory timeout
//  state        out  4  current state encoding (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 RWB=7 BRANCH=8 JUMP=9 ADDIEX=10 ADDIWB=11 HALT=15.
//  Reset: state=FETCH, fault=00, timeout counter=0; all outputs 0 except FETCH decode below.
//  Unlisted outputs are 0 in every state.
//  FETCH: memRead=1,iord=0,aluSrcA=0,aluSrcB=01,aluOp=00. While memReady=0 stay. When memReady=1 (same cycle):
//    irWrite=1,pcWrite=1,pcSrc=00; next DECODE.
//  DECODE: aluSrcA=0,aluSrcB=11,aluOp=00 (branch target to ALUOut). Next by opcode:
//    000000 EXEC; 100011/101011 MEMADR; 000100 BRANCH; 000010 JUMP; 001000 ADDIEX; other -> HALT, fault=01.
//  EXEC: aluSrcA=1,aluSrcB=00,aluOp=10 -> RWB.  RWB: regDst=1,regWrite=1,instrDone=1 -> FETCH.
//  MEMADR: aluSrcA=1,aluSrcB=10,aluOp=00 -> MEMRD if lw else MEMWR.
//  MEMRD: memRead=1,iord=1; wait memReady -> MEMWB.  MEMWB: regDst=0,memToReg=1,regWrite=1,instrDone=1 -> FETCH.
//  MEMWR: memWrite=1,iord=1; on memReady: instrDone=1 -> FETCH; else stay.
//  BRANCH: aluSrcA=1,aluSrcB=00,aluOp=01,pcSrc=01,pcWrite=zero,instrDone=1 -> FETCH.
//  JUMP: pcSrc=10,pcWrite=1,instrDone=1 -> FETCH.
//  ADDIEX: aluSrcA=1,aluSrcB=10,aluOp=00 -> ADDIWB.  ADDIWB: regDst=0,regWrite=1,instrDone=1 -> FETCH.
//  Latency with memReady=1 immediately: R/addi/sw 4 clk, lw 5, beq/j 3. Each memReady wait adds 1 clk.
//  Timeout: 8-bit counter clears on entry to FETCH/MEMRD/MEMWR and on memReady; increments each waiting cycle.
//    Reaching MEM_TIMEOUT waiting cycles without memReady -> HALT, fault=10; request deasserted in HALT.
//  memReady outside FETCH/MEMRD/MEMWR is ignored. memRead/memWrite never both 1.
//  HALT: all controls 0, instrDone=0; stays until rst. fault is sticky, cleared only by rst.
//  rst mid-instruction (any state) wins over all transitions: next cycle FETCH, no write strobes in reset cycle.
// TESTING
//  1 rst high 2 clk, memReady=1 -> state=0, fault=00, memRead=1, all other strobes 0.
//  2 opcode=000000, memReady=1 always -> states 0,1,6,7; regWrite=1,regDst=1 in 4th clk; instrDone once.
//  3 lw (100011), memReady low 2 clk in MEMRD -> 0,1,2,3,3,3,4; memToReg=1,regWrite=1 in MEMWB; total 7 clk.
//  4 beq (000100) zero=0 then zero=1 -> 3 clk each; pcWrite=0 / pcWrite=1 with pcSrc=01 in BRANCH.
//  5 opcode=111111 -> HALT after DECODE, fault=01, all strobes 0 for 20 clk; rst returns to FETCH, fault=00.
//  6 sw with memReady held 0 -> after MEM_TIMEOUT=15 waits in MEMWR go HALT, fault=10, memWrite drops; rst mid-MEMRD -> FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control FSM with memory handshake, illegal-opcode and timeout trapping
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       memReady,
   output logic       pcWrite,
   output logic [1:0] pcSrc,
   output logic       irWrite,
   output logic       iord,
   output logic       memRead,
   output logic       memWrite,
   output logic       regWrite,
   output logic       regDst,
   output logic       memToReg,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] aluOp,
   output logic       instrDone,
   output logic [1:0] fault,
   output logic [3:0] state
);
   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11,
      HALT   = 4'd15
   } stateT;
   localparam logic [5:0] OpR    = 6'b000000;
   localparam logic [5:0] OpLw   = 6'b100011;
   localparam logic [5:0] OpSw   = 6'b101011;
   localparam logic [5:0] OpBeq  = 6'b000100;
   localparam logic [5:0] OpJ    = 6'b000010;
   localparam logic [5:0] OpAddi = 6'b001000;
   stateT cur, nxt;
   logic [7:0] waitCnt, waitNxt;
   logic [1:0] faultNxt;
   logic timedOut;
   assign state = cur;
   assign timedOut = waitCnt == 8'(MEM_TIMEOUT - 1);
   // state, memory-wait counter and sticky fault register
   always_ff @(posedge clk) begin
      if (rst) begin
         cur     <= FETCH;
         waitCnt <= '0;
         fault   <= '0;
      end else begin
         cur     <= nxt;
         waitCnt <= waitNxt;
         fault   <= faultNxt;
      end
   end
   // next state and datapath controls; the wait counter only survives consecutive unready memory cycles
   always_comb begin
      nxt       = cur;
      waitNxt   = '0;
      faultNxt  = fault;
      pcWrite   = 1'b0;
      pcSrc     = 2'b00;
      irWrite   = 1'b0;
      iord      = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      regWrite  = 1'b0;
      regDst    = 1'b0;
      memToReg  = 1'b0;
      aluSrcA   = 1'b0;
      aluSrcB   = 2'b00;
      aluOp     = 2'b00;
      instrDone = 1'b0;
      case (cur)
         FETCH: begin
            memRead = 1'b1;
            aluSrcB = 2'b01;
            if (memReady) begin
               irWrite = 1'b1;
               pcWrite = 1'b1;
               nxt     = DECODE;
            end else if (timedOut) begin
               nxt      = HALT;
               faultNxt = 2'b10;
            end else waitNxt = waitCnt + 8'd1;
         end
         DECODE: begin
            aluSrcB = 2'b11;
            case (opcode)
               OpR:        nxt = EXEC;
               OpLw, OpSw: nxt = MEMADR;
               OpBeq:      nxt = BRANCH;
               OpJ:        nxt = JUMP;
               OpAddi:     nxt = ADDIEX;
               default: begin
                  nxt      = HALT;
                  faultNxt = 2'b01;
               end
            endcase
         end
         EXEC: begin
            aluSrcA = 1'b1;
            aluOp   = 2'b10;
            nxt     = RWB;
         end
         RWB: begin
            regDst    = 1'b1;
            regWrite  = 1'b1;
            instrDone = 1'b1;
            nxt       = FETCH;
         end
         MEMADR: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            nxt     = opcode == OpLw ? MEMRD : MEMWR;
         end
         MEMRD: begin
            memRead = 1'b1;
            iord    = 1'b1;
            if (memReady) nxt = MEMWB;
            else if (timedOut) begin
               nxt      = HALT;
               faultNxt = 2'b10;
            end else waitNxt = waitCnt + 8'd1;
         end
         MEMWB: begin
            memToReg  = 1'b1;
            regWrite  = 1'b1;
            instrDone = 1'b1;
            nxt       = FETCH;
         end
         MEMWR: begin
            memWrite = 1'b1;
            iord     = 1'b1;
            if (memReady) begin
               instrDone = 1'b1;
               nxt       = FETCH;
            end else if (timedOut) begin
               nxt      = HALT;
               faultNxt = 2'b10;
            end else waitNxt = waitCnt + 8'd1;
         end
         BRANCH: begin
            aluSrcA   = 1'b1;
            aluOp     = 2'b01;
            pcSrc     = 2'b01;
            pcWrite   = zero;
            instrDone = 1'b1;
            nxt       = FETCH;
         end
         JUMP: begin
            pcSrc     = 2'b10;
            pcWrite   = 1'b1;
            instrDone = 1'b1;
            nxt       = FETCH;
         end
         ADDIEX: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            nxt     = ADDIWB;
         end
         ADDIWB: begin
            regWrite  = 1'b1;
            instrDone = 1'b1;
            nxt       = FETCH;
         end
         default: nxt = HALT;
      endcase
      if (rst) begin
         pcWrite   = 1'b0;
         irWrite   = 1'b0;
         memWrite  = 1'b0;
         regWrite  = 1'b0;
         instrDone = 1'b0;
      end
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized scoreboard bench for the multi-cycle control FSM
module tb_multicycle_ctrl;
   localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
   localparam logic [5:0] OpBeq = 6'b000100, OpJ = 6'b000010, OpAddi = 6'b001000;
   logic clk = 1'b0, rst = 1'b1, zero = 1'b0, memReady = 1'b1;
   logic [5:0] opcode = '0;
   logic pcWrite, irWrite, iord, memRead, memWrite, regWrite, regDst, memToReg, aluSrcA, instrDone;
   logic [1:0] pcSrc, aluSrcB, aluOp, fault;
   logic [3:0] state;
   multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .memReady(memReady),
      .pcWrite(pcWrite), .pcSrc(pcSrc), .irWrite(irWrite), .iord(iord), .memRead(memRead),
      .memWrite(memWrite), .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
      .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .instrDone(instrDone),
      .fault(fault), .state(state)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [5:0]  op;
      int          len;
      logic [63:0] seq;
      int          nRegW;
      logic        rDst;
      logic        m2r;
      int          nPcW;
      logic [1:0]  pcS;
      int          nIrW;
      int          nMemRd;
      int          nMemWr;
   } expT;
   expT sb[$];
   int checks = 0, errors = 0;
   logic monOn = 1'b0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask
   // monitor: tallies observed controls per instruction and scores them when instrDone pulses
   expT mE;
   int mLen = 0, mRegW = 0, mPcW = 0, mIrW = 0, mRd = 0, mWr = 0;
   logic [63:0] mSeq = '0;
   logic mDst = 1'b0, mM2r = 1'b0;
   logic [1:0] mPcS = '0;
   always @(negedge clk) begin
      if (monOn) begin
         mSeq = (mSeq << 4) | 64'(state);
         mLen++;
         if (regWrite) begin mRegW++; mDst = regDst; mM2r = memToReg; end
         if (pcWrite) begin mPcW++; mPcS = pcSrc; end
         if (irWrite) mIrW++;
         if (memRead) mRd++;
         if (memWrite) mWr++;
         chk("rd_wr_exclusive", 64'(memRead & memWrite), 64'd0);
         if (instrDone) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got instrDone in state %0d expected none", state);
            end else begin
               mE = sb.pop_front();
               chk($sformatf("op%02h_len", mE.op), 64'(mLen), 64'(mE.len));
               chk($sformatf("op%02h_states", mE.op), mSeq, mE.seq);
               chk($sformatf("op%02h_regwrites", mE.op), 64'(mRegW), 64'(mE.nRegW));
               chk($sformatf("op%02h_regdst_memtoreg", mE.op), {62'd0, mDst, mM2r}, {62'd0, mE.rDst, mE.m2r});
               chk($sformatf("op%02h_pcwrites", mE.op), 64'(mPcW), 64'(mE.nPcW));
               chk($sformatf("op%02h_pcsrc", mE.op), 64'(mPcS), 64'(mE.pcS));
               chk($sformatf("op%02h_irwrites", mE.op), 64'(mIrW), 64'(mE.nIrW));
               chk($sformatf("op%02h_memreads", mE.op), 64'(mRd), 64'(mE.nMemRd));
               chk($sformatf("op%02h_memwrites", mE.op), 64'(mWr), 64'(mE.nMemWr));
               chk($sformatf("op%02h_fault", mE.op), 64'(fault), 64'd0);
            end
            mLen = 0; mRegW = 0; mPcW = 0; mIrW = 0; mRd = 0; mWr = 0;
            mSeq = '0; mDst = 1'b0; mM2r = 1'b0; mPcS = '0;
         end
      end
   end
   // reference model: builds the expected state path and memReady schedule for one instruction
   logic [63:0] tSeq;
   int tLen;
   logic tSched[$];
   task automatic addCyc(input logic [3:0] s, input logic r);
      tSeq = (tSeq << 4) | 64'(s);
      tLen++;
      tSched.push_back(r);
   endtask
   task automatic runInstr(input logic [5:0] op, input logic z, input int wF, input int wM);
      expT e;
      tSeq = '0;
      tLen = 0;
      tSched.delete();
      e.op = op; e.nRegW = 0; e.rDst = 1'b0; e.m2r = 1'b0; e.nPcW = 1; e.pcS = 2'b00;
      e.nIrW = 1; e.nMemRd = wF + 1; e.nMemWr = 0;
      for (int i = 0; i < wF; i++) addCyc(4'd0, 1'b0);
      addCyc(4'd0, 1'b1);
      addCyc(4'd1, 1'($urandom_range(0, 1)));
      case (op)
         OpR: begin
            addCyc(4'd6, 1'($urandom_range(0, 1)));
            addCyc(4'd7, 1'($urandom_range(0, 1)));
            e.nRegW = 1; e.rDst = 1'b1;
         end
         OpAddi: begin
            addCyc(4'd10, 1'($urandom_range(0, 1)));
            addCyc(4'd11, 1'($urandom_range(0, 1)));
            e.nRegW = 1;
         end
         OpLw: begin
            addCyc(4'd2, 1'($urandom_range(0, 1)));
            for (int i = 0; i < wM; i++) addCyc(4'd3, 1'b0);
            addCyc(4'd3, 1'b1);
            addCyc(4'd4, 1'($urandom_range(0, 1)));
            e.nRegW = 1; e.m2r = 1'b1; e.nMemRd += wM + 1;
         end
         OpSw: begin
            addCyc(4'd2, 1'($urandom_range(0, 1)));
            for (int i = 0; i < wM; i++) addCyc(4'd5, 1'b0);
            addCyc(4'd5, 1'b1);
            e.nMemWr = wM + 1;
         end
         OpBeq: begin
            addCyc(4'd8, 1'($urandom_range(0, 1)));
            e.nPcW += int'(z); e.pcS = z ? 2'b01 : 2'b00;
         end
         default: begin
            addCyc(4'd9, 1'($urandom_range(0, 1)));
            e.nPcW = 2; e.pcS = 2'b10;
         end
      endcase
      e.len = tLen;
      e.seq = tSeq;
      sb.push_back(e);
      foreach (tSched[i]) begin
         opcode = op;
         zero = z;
         memReady = tSched[i];
         @(posedge clk); #1;
      end
   endtask
   logic [5:0] opTab[6];
   logic [16:0] ctl;
   logic bad;
   assign ctl = {pcWrite, pcSrc, irWrite, iord, memRead, memWrite, regWrite, regDst, memToReg,
                 aluSrcA, aluSrcB, aluOp, instrDone};
   initial begin
      opTab = '{OpR, OpLw, OpSw, OpBeq, OpJ, OpAddi};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 64'(state), 64'd0);
      chk("reset_fault", 64'(fault), 64'd0);
      chk("reset_memread", 64'(memRead), 64'd1);
      chk("reset_strobes", 64'({pcWrite, irWrite, memWrite, regWrite, instrDone}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      monOn = 1'b1;
      runInstr(OpR, 1'b0, 0, 0);
      runInstr(OpLw, 1'b0, 0, 2);
      runInstr(OpBeq, 1'b0, 0, 0);
      runInstr(OpBeq, 1'b1, 0, 0);
      runInstr(OpJ, 1'b0, 0, 0);
      runInstr(OpSw, 1'b1, 0, 0);
      runInstr(OpAddi, 1'b0, 0, 0);
      for (int n = 0; n < 40; n++)
         runInstr(opTab[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      monOn = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; opcode = 6'h3f; memReady = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("illegal_state", 64'(state), 64'd15);
      chk("illegal_fault", 64'(fault), 64'd1);
      bad = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         memReady = 1'($urandom_range(0, 1));
         @(negedge clk);
         bad |= (ctl != '0) || (state != 4'd15) || (fault != 2'b01);
      end
      chk("halt_quiet_20clk", 64'(bad), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("halt_rst_state", 64'(state), 64'd0);
      chk("halt_rst_fault", 64'(fault), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; opcode = OpSw; memReady = 1'b1;
      @(posedge clk); #1;
      memReady = 1'b0;
      repeat (16) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("sw_wait15_state", 64'(state), 64'd5);
      chk("sw_wait15_memwrite", 64'(memWrite), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("timeout_state", 64'(state), 64'd15);
      chk("timeout_fault", 64'(fault), 64'd2);
      chk("timeout_req_drop", 64'({memWrite, memRead}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; opcode = OpLw; memReady = 1'b1;
      @(posedge clk); #1;
      memReady = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("lw_memrd_state", 64'(state), 64'd3);
      chk("lw_memrd_fault", 64'(fault), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_mid_memrd", 64'(state), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; opcode = OpR; memReady = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_rwb_state", 64'(state), 64'd7);
      chk("rst_in_rwb_strobes", 64'({regWrite, instrDone}), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_rwb_to_fetch", 64'(state), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
